// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: mode encoding, block geometry and padder FSM states.
// Used by the message padder and by the hash core that consumes its word stream.
package sha2_pkg;

    typedef enum logic [1:0] {
        SHA_224 = 2'b00,
        SHA_256 = 2'b01,
        SHA_384 = 2'b10,
        SHA_512 = 2'b11
    } sha_type_t;

    localparam int BLOCK_WORDS = 16;
    localparam int LEN_HI_IDX  = 14;
    localparam int LEN_LO_IDX  = 15;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD80,
        ZERO,
        LEN_HI,
        LEN_LO
    } pad_state_t;

    // Upper bit of the type selects the 64-bit word family (SHA-384/512).
    function automatic logic is_sha512(input sha_type_t t);
        return t[1];
    endfunction

    // tkeep is MSB-contiguous, so the population count is the byte count.
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, keep[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sha2_pad_word.sv
// Combinational pad helper: keeps the first nbytes_i bytes of a word, drops 0x80 right
// after them and zeroes the tail. SHA-256 words live in [31:0], SHA-512 words in [63:0].
module sha2_pad_word (
    input  logic [63:0] word_i,
    input  logic [3:0]  nbytes_i,
    input  logic        sha512_i,
    output logic [63:0] word_o,
    output logic        room_o
);

    logic [3:0] top_slot;

    assign top_slot = sha512_i ? 4'd7 : 4'd3;
    assign room_o   = nbytes_i < (sha512_i ? 4'd8 : 4'd4);

    // Slot s holds word_o[8*s +: 8]; message byte index is top_slot - s (byte0 = MSB).
    always_comb begin
        word_o = '0;
        for (int s = 0; s < 8; s++) begin
            if (s <= int'(top_slot)) begin
                if ((int'(top_slot) - s) < int'(nbytes_i)) begin
                    word_o[8*s +: 8] = word_i[8*s +: 8];
                end else if ((int'(top_slot) - s) == int'(nbytes_i)) begin
                    word_o[8*s +: 8] = 8'h80;
                end
            end
        end
    end

endmodule

// File: rtl/sha2_msg_padder.sv
// Converts an AXIS byte stream into FIPS 180-4 padded 16-word blocks for the hash core,
// in SHA-256 (32b words) or SHA-512 (64b words) mode chosen by the first-beat tuser.
module sha2_msg_padder
    import sha2_pkg::*;
#(
    parameter int TUSER_WIDTH  = 128,
    parameter int SHA_TYPE_LSB = 32
) (
    input  logic                   axi_aclk,
    input  logic                   axi_reset,
    input  logic [63:0]            s_axis_tdata,
    input  logic [7:0]             s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [63:0]            m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);

    pad_state_t             state_q, state_d;
    logic [3:0]             word_cnt_q, word_cnt_d;
    logic [60:0]            byte_cnt_q, byte_cnt_d;
    logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic                   sha512_q, sha512_d;
    logic                   half_q, half_d;
    logic                   pad_done_q, pad_done_d;
    logic [63:0]            out_data_q, out_data_d;
    logic                   out_vld_q, out_vld_d;
    logic                   out_last_q, out_last_d;

    logic        load;
    logic        ignore_beat;
    logic        low_zero;
    logic [3:0]  beat_bytes, hi_bytes, lo_bytes, pw_nbytes;
    logic [63:0] pw_word, pw_out, len_bits;
    logic        pw_room;
    pad_state_t  after_pad;
    logic        emit;
    logic [63:0] emit_word;
    logic        emit_last;

    assign load        = !out_vld_q || m_axis_tready;
    assign beat_bytes  = keep_count(s_axis_tkeep);
    assign hi_bytes    = (beat_bytes > 4'd4) ? 4'd4 : beat_bytes;
    assign lo_bytes    = (beat_bytes > 4'd4) ? (beat_bytes - 4'd4) : 4'd0;
    assign ignore_beat = s_axis_tvalid && (s_axis_tkeep == 8'h00) && !s_axis_tlast;
    // Once 0x80 landed in the high half, the low half of that beat is plain zero fill.
    assign low_zero    = half_q && pad_done_q;
    assign len_bits    = {byte_cnt_q, 3'b000};
    assign after_pad   = (word_cnt_q == 4'(LEN_HI_IDX - 1)) ? LEN_HI : ZERO;

    assign pw_word = sha512_q ? s_axis_tdata
                              : {32'h0, half_q ? s_axis_tdata[31:0] : s_axis_tdata[63:32]};

    always_comb begin
        pw_nbytes = sha512_q ? 4'd8 : 4'd4;
        if (s_axis_tlast) begin
            if (sha512_q)    pw_nbytes = beat_bytes;
            else if (half_q) pw_nbytes = lo_bytes;
            else             pw_nbytes = hi_bytes;
        end
    end

    sha2_pad_word u_pad_word (
        .word_i   (pw_word),
        .nbytes_i (pw_nbytes),
        .sha512_i (sha512_q),
        .word_o   (pw_out),
        .room_o   (pw_room)
    );

    assign s_axis_tready = (state_q == DATA) && load && (ignore_beat || sha512_q || half_q);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tuser_d    = tuser_q;
        sha512_d   = sha512_q;
        half_d     = half_q;
        pad_done_d = pad_done_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        emit       = 1'b0;
        emit_word  = '0;
        emit_last  = 1'b0;

        if (out_vld_q && m_axis_tready) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d    = DATA;
                    tuser_d    = s_axis_tuser;
                    sha512_d   = is_sha512(sha_type_t'(s_axis_tuser[SHA_TYPE_LSB +: 2]));
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    half_d     = 1'b0;
                    pad_done_d = 1'b0;
                end
            end
            DATA: begin
                if (s_axis_tvalid && load && !ignore_beat) begin
                    emit      = 1'b1;
                    emit_word = low_zero ? 64'h0 : pw_out;
                    if (sha512_q || half_q) begin
                        half_d     = 1'b0;
                        byte_cnt_d = byte_cnt_q + 61'(beat_bytes);
                        if (s_axis_tlast) begin
                            state_d = (low_zero || pw_room) ? after_pad : PAD80;
                        end
                    end else begin
                        half_d     = 1'b1;
                        pad_done_d = s_axis_tlast && pw_room;
                    end
                end
            end
            PAD80: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_word = sha512_q ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                    state_d   = after_pad;
                end
            end
            ZERO: begin
                if (load) begin
                    emit    = 1'b1;
                    state_d = after_pad;
                end
            end
            LEN_HI: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_word = sha512_q ? 64'h0 : {32'h0, len_bits[63:32]};
                    state_d   = LEN_LO;
                end
            end
            LEN_LO: begin
                // The final word is held here until the consumer takes it.
                if (out_vld_q && out_last_q) begin
                    if (m_axis_tready) state_d = IDLE;
                end else if (load) begin
                    emit      = 1'b1;
                    emit_word = sha512_q ? len_bits : {32'h0, len_bits[31:0]};
                    emit_last = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            out_vld_d  = 1'b1;
            out_data_d = emit_word;
            out_last_d = emit_last;
            word_cnt_d = word_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            tuser_q    <= '0;
            sha512_q   <= 1'b0;
            half_q     <= 1'b0;
            pad_done_q <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tuser_q    <= tuser_d;
            sha512_q   <= sha512_d;
            half_q     <= half_d;
            pad_done_q <= pad_done_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_sha2_msg_padder.sv
// Scoreboard bench for sha2_msg_padder: directed messages push expected padded words,
// a negedge monitor pops and compares every accepted output word.
module tb_sha2_msg_padder;

    localparam int TW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   s_axis_tdata = '0;
    logic [7:0]    s_axis_tkeep = '0;
    logic [TW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [63:0]   m_axis_tdata;
    logic [TW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;

    sha2_msg_padder #(.TUSER_WIDTH(TW), .SHA_TYPE_LSB(32)) dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]   data;
        logic          last;
        logic [TW-1:0] tuser;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            word_idx = 0;
    logic          sb_en = 1'b0;
    logic          rand_ready = 1'b0;
    logic [TW-1:0] cur_tuser;
    logic [63:0]   beats[7];

    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data;
    logic          prev_last;

    // Monitor: a word is consumed at the posedge following a negedge with valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_en) begin
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold word %0d: got v=%b d=%h l=%b, held d=%h l=%b",
                             word_idx, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got d=%h l=%b, expected none", m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.tuser) begin
                        errors++;
                        $display("FAIL word %0d: got d=%h l=%b u=%h, expected d=%h l=%b u=%h",
                                 word_idx, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.tuser);
                    end
                end
                word_idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [63:0] d, input logic l);
        exp_t e;
        e.data  = d;
        e.last  = l;
        e.tuser = cur_tuser;
        exp_q.push_back(e);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) push(64'h0, 1'b0);
    endtask

    function automatic logic [TW-1:0] mk_tuser(input logic [1:0] st, input logic [31:0] tag);
        logic [TW-1:0] u;
        u          = '0;
        u[127:96]  = 32'hCAFE_F00D;
        u[95:64]   = tag;
        u[33:32]   = st;
        u[31:0]    = 32'h1234_5678 ^ tag;
        return u;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int   n;
        logic fire;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = cur_tuser;
        s_axis_tvalid = 1'b1;
        n = 0;
        fire = 1'b0;
        while (!fire && n < 300) begin
            @(negedge clk);
            fire = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (!fire) begin
            errors++;
            $display("FAIL beat_accept: got no tready in %0d cycles, expected handshake", n);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d words missing, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'h0 ||
            m_axis_tuser !== '0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b l=%b d=%h u=%h rdy=%b, expected all zero",
                     name, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser, s_axis_tready);
        end
    endtask

    task automatic run_abc256(input logic [31:0] tag);
        cur_tuser = mk_tuser(2'b01, tag);
        push(64'h0000_0000_6162_6380, 1'b0);
        push_zeros(14);
        push(64'h18, 1'b1);
        send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1);
        drain("sha256_abc");
    endtask

    initial begin
        for (int k = 0; k < 7; k++) beats[k] = 64'h0001_0203_0405_0607 + 64'(k) * 64'h0808_0808_0808_0808;

        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("idle_after_reset");
        sb_en = 1'b1;

        // SHA-256 "abc"
        run_abc256(32'h1);

        // SHA-512 "abc"
        cur_tuser = mk_tuser(2'b10, 32'h2);
        push(64'h6162_6380_0000_0000, 1'b0);
        push_zeros(14);
        push(64'h18, 1'b1);
        send_beat(64'h6162_6300_0000_0000, 8'hE0, 1'b1);
        drain("sha512_abc");

        // SHA-256 56 bytes: 0x80 lands at word 14, forcing a second block
        cur_tuser = mk_tuser(2'b01, 32'h3);
        for (int k = 0; k < 7; k++) begin
            push({32'h0, beats[k][63:32]}, 1'b0);
            push({32'h0, beats[k][31:0]}, 1'b0);
        end
        push(64'h8000_0000, 1'b0);
        push_zeros(16);
        push(64'h1C0, 1'b1);
        for (int k = 0; k < 7; k++) send_beat(beats[k], 8'hFF, k == 6);
        drain("sha256_56B");

        // SHA-512 empty message
        cur_tuser = mk_tuser(2'b11, 32'h4);
        push(64'h8000_0000_0000_0000, 1'b0);
        push_zeros(14);
        push(64'h0, 1'b1);
        send_beat(64'h0, 8'h00, 1'b1);
        drain("sha512_empty");

        // SHA-256 "abcd": high half full, 0x80 word is the low half
        cur_tuser = mk_tuser(2'b01, 32'h7);
        push(64'h6162_6364, 1'b0);
        push(64'h8000_0000, 1'b0);
        push_zeros(13);
        push(64'h20, 1'b1);
        send_beat(64'h6162_6364_0000_0000, 8'hF0, 1'b1);
        drain("sha256_abcd");

        // 56-byte SHA-256 message again under random backpressure
        rand_ready = 1'b1;
        cur_tuser = mk_tuser(2'b00, 32'h5);
        for (int k = 0; k < 7; k++) begin
            push({32'h0, beats[k][63:32]}, 1'b0);
            push({32'h0, beats[k][31:0]}, 1'b0);
        end
        push(64'h8000_0000, 1'b0);
        push_zeros(16);
        push(64'h1C0, 1'b1);
        for (int k = 0; k < 7; k++) send_beat(beats[k], 8'hFF, k == 6);
        drain("backpressure");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of DATA drops the message
        sb_en = 1'b0;
        cur_tuser = mk_tuser(2'b01, 32'h6);
        s_axis_tdata  = 64'h0102_0304_0506_0708;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = cur_tuser;
        s_axis_tvalid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_cleared("midmsg_reset");
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        run_abc256(32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
